// File: rtl/axi_mem_responder_if.sv
// AXI4 channel bundle shared by the memory responder and its requesters.
interface axi_channel #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDR_WIDTH    = 48,
  parameter int DATA_WIDTH    = 64,
  parameter int AW_USER_WIDTH = 1,
  parameter int AR_USER_WIDTH = 1,
  parameter int W_USER_WIDTH  = 1,
  parameter int R_USER_WIDTH  = 1,
  parameter int B_USER_WIDTH  = 1
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                     clk;
  logic                     rstn;
  // write address
  logic [ID_WIDTH-1:0]      aw_id;
  logic [ADDR_WIDTH-1:0]    aw_addr;
  logic [7:0]               aw_len;
  logic [2:0]               aw_size;
  logic [1:0]               aw_burst;
  logic                     aw_lock;
  logic [3:0]               aw_cache;
  logic [2:0]               aw_prot;
  logic [3:0]               aw_qos;
  logic [3:0]               aw_region;
  logic [AW_USER_WIDTH-1:0] aw_user;
  logic                     aw_valid;
  logic                     aw_ready;
  // write data
  logic [DATA_WIDTH-1:0]    w_data;
  logic [STRB_WIDTH-1:0]    w_strb;
  logic                     w_last;
  logic [W_USER_WIDTH-1:0]  w_user;
  logic                     w_valid;
  logic                     w_ready;
  // write response
  logic [ID_WIDTH-1:0]      b_id;
  logic [1:0]               b_resp;
  logic [B_USER_WIDTH-1:0]  b_user;
  logic                     b_valid;
  logic                     b_ready;
  // read address
  logic [ID_WIDTH-1:0]      ar_id;
  logic [ADDR_WIDTH-1:0]    ar_addr;
  logic [7:0]               ar_len;
  logic [2:0]               ar_size;
  logic [1:0]               ar_burst;
  logic                     ar_lock;
  logic [3:0]               ar_cache;
  logic [2:0]               ar_prot;
  logic [3:0]               ar_qos;
  logic [3:0]               ar_region;
  logic [AR_USER_WIDTH-1:0] ar_user;
  logic                     ar_valid;
  logic                     ar_ready;
  // read data
  logic [ID_WIDTH-1:0]      r_id;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [1:0]               r_resp;
  logic                     r_last;
  logic [R_USER_WIDTH-1:0]  r_user;
  logic                     r_valid;
  logic                     r_ready;

  modport slave (
    input  clk, rstn,
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

  modport master (
    input  clk, rstn,
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: byte-lane RAM with independent write and read burst engines.
module axi_mem_responder #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDR_WIDTH    = 48,
  parameter int DATA_WIDTH    = 64,
  parameter int AW_USER_WIDTH = 1,
  parameter int AR_USER_WIDTH = 1,
  parameter int W_USER_WIDTH  = 1,
  parameter int R_USER_WIDTH  = 1,
  parameter int B_USER_WIDTH  = 1,
  parameter int MEM_WORDS     = 1024
) (
  input  logic      clk,
  input  logic      rst,
  axi_channel.slave master
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SHIFT      = $clog2(STRB_WIDTH);
  localparam int IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] A_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]            MAX_SIZE  = 3'(SHIFT);

  if ($bits(master.aw_id) != ID_WIDTH || $bits(master.aw_addr) != ADDR_WIDTH ||
      $bits(master.w_data) != DATA_WIDTH || $bits(master.w_strb) != STRB_WIDTH ||
      $bits(master.aw_user) != AW_USER_WIDTH || $bits(master.ar_user) != AR_USER_WIDTH ||
      $bits(master.w_user) != W_USER_WIDTH || $bits(master.r_user) != R_USER_WIDTH ||
      $bits(master.b_user) != B_USER_WIDTH) begin : g_param_mismatch
    $fatal(1, "Parameter mismatch");
  end

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Address of the beat following a, for the given burst shape.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, incr, wrap_mask;
    step      = A_ONE << size;
    incr      = (a & ~(step - A_ONE)) + step;
    wrap_mask = ((ADDR_WIDTH'(len) + A_ONE) << size) - A_ONE;
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~wrap_mask) | (incr & wrap_mask);
      default: return incr;
    endcase
  endfunction

  // Burst shapes the responder refuses outright.
  function automatic logic f_cfg_err(input logic [2:0] size, input logic [7:0] len,
      input logic [1:0] burst);
    return (size > MAX_SIZE) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    return a < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> SHIFT);
  endfunction

  // ---------------- write engine ----------------
  w_state_t              r_w_state, w_w_state_next;
  logic [ID_WIDTH-1:0]   r_aw_id;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [7:0]            r_aw_len, r_w_cnt;
  logic [2:0]            r_aw_size;
  logic [1:0]            r_aw_burst;
  logic                  r_w_err, r_w_dec;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_w_early_last, w_w_en;
  logic [IDX_W-1:0]      w_wr_idx;

  assign master.aw_ready = (r_w_state == W_IDLE) && !rst;
  assign master.w_ready  = (r_w_state == W_DATA) && !rst;
  assign master.b_valid  = (r_w_state == W_RESP) && !rst;
  assign master.b_id     = r_aw_id;
  assign master.b_resp   = r_w_err ? 2'b10 : (r_w_dec ? 2'b11 : 2'b00);
  assign master.b_user   = '0;

  assign w_aw_hs        = master.aw_valid && master.aw_ready;
  assign w_w_hs         = master.w_valid && master.w_ready;
  assign w_b_hs         = master.b_valid && master.b_ready;
  assign w_w_early_last = master.w_last && (r_w_cnt != r_aw_len);
  assign w_w_en         = w_w_hs && !r_w_err && !w_w_early_last && f_in_range(r_aw_addr);
  assign w_wr_idx       = f_idx(r_aw_addr);

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_w_state <= W_IDLE;
    else     r_w_state <= w_w_state_next;
  end

  // Write FSM next state: a burst ends on w_last whatever the beat count.
  always_comb begin
    w_w_state_next = r_w_state;
    case (r_w_state)
      W_IDLE:  if (w_aw_hs) w_w_state_next = W_DATA;
      W_DATA:  if (w_w_hs && master.w_last) w_w_state_next = W_RESP;
      W_RESP:  if (w_b_hs) w_w_state_next = W_IDLE;
      default: w_w_state_next = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: current beat address, beat count and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_id <= '0; r_aw_addr <= '0; r_aw_len <= '0; r_aw_size <= '0;
      r_aw_burst <= '0; r_w_cnt <= '0; r_w_err <= 1'b0; r_w_dec <= 1'b0;
    end else if (w_aw_hs) begin
      r_aw_id    <= master.aw_id;
      r_aw_addr  <= master.aw_addr;
      r_aw_len   <= master.aw_len;
      r_aw_size  <= master.aw_size;
      r_aw_burst <= master.aw_burst;
      r_w_cnt    <= '0;
      r_w_err    <= f_cfg_err(master.aw_size, master.aw_len, master.aw_burst);
      r_w_dec    <= 1'b0;
    end else if (w_w_hs) begin
      r_aw_addr <= f_next_addr(r_aw_addr, r_aw_size, r_aw_len, r_aw_burst);
      r_w_cnt   <= r_w_cnt + 8'd1;
      if (w_w_early_last) r_w_err <= 1'b1;
      if (!f_in_range(r_aw_addr)) r_w_dec <= 1'b1;
    end
  end

  // ---------------- storage ----------------
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [IDX_W-1:0]      w_rd_idx;

  assign w_rd_idx = f_idx(w_rd_addr);

  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
    logic [7:0] r_mem [MEM_WORDS];
    // One byte lane; deliberately never reset so contents survive rst.
    always_ff @(posedge clk) begin
      if (w_w_en && master.w_strb[gi]) r_mem[w_wr_idx] <= master.w_data[gi*8 +: 8];
    end
    assign w_rd_word[gi*8 +: 8] = r_mem[w_rd_idx];
  end

  // ---------------- read engine ----------------
  r_state_t              r_r_state, w_r_state_next;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [7:0]            r_ar_len, r_ar_cnt;
  logic [2:0]            r_ar_size;
  logic [1:0]            r_ar_burst;
  logic                  r_ar_err;
  logic [ID_WIDTH-1:0]   r_r_id;
  logic [DATA_WIDTH-1:0] r_r_data;
  logic [1:0]            r_r_resp;
  logic                  r_r_last, r_r_valid;
  logic                  w_ar_hs, w_r_hs, w_rd_load, w_rd_err, w_rd_last;

  assign master.ar_ready = (r_r_state == R_IDLE) && !rst;
  assign master.r_valid  = r_r_valid;
  assign master.r_id     = r_r_id;
  assign master.r_data   = r_r_data;
  assign master.r_resp   = r_r_resp;
  assign master.r_last   = r_r_last;
  assign master.r_user   = '0;

  assign w_ar_hs   = master.ar_valid && master.ar_ready;
  assign w_r_hs    = r_r_valid && master.r_ready;
  assign w_rd_load = w_ar_hs || (w_r_hs && !r_r_last);

  // Beat to load next: the AR request itself when idle, else the follow-on beat.
  always_comb begin
    w_rd_addr = f_next_addr(r_ar_addr, r_ar_size, r_ar_len, r_ar_burst);
    w_rd_err  = r_ar_err;
    w_rd_last = (r_ar_cnt + 8'd1) == r_ar_len;
    if (r_r_state == R_IDLE) begin
      w_rd_addr = master.ar_addr;
      w_rd_err  = f_cfg_err(master.ar_size, master.ar_len, master.ar_burst);
      w_rd_last = (master.ar_len == 8'd0);
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_r_state <= R_IDLE;
    else     r_r_state <= w_r_state_next;
  end

  // Read FSM next state.
  always_comb begin
    w_r_state_next = r_r_state;
    case (r_r_state)
      R_IDLE:  if (w_ar_hs) w_r_state_next = R_DATA;
      R_DATA:  if (w_r_hs && r_r_last) w_r_state_next = R_IDLE;
      default: w_r_state_next = R_IDLE;
    endcase
  end

  // Read datapath: registered beat output, held while the requester stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar_addr <= '0; r_ar_len <= '0; r_ar_size <= '0; r_ar_burst <= '0;
      r_ar_cnt <= '0; r_ar_err <= 1'b0; r_r_id <= '0; r_r_data <= '0;
      r_r_resp <= '0; r_r_last <= 1'b0; r_r_valid <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_r_id     <= master.ar_id;
        r_ar_addr  <= master.ar_addr;
        r_ar_len   <= master.ar_len;
        r_ar_size  <= master.ar_size;
        r_ar_burst <= master.ar_burst;
        r_ar_err   <= w_rd_err;
        r_ar_cnt   <= '0;
      end else if (w_r_hs && !r_r_last) begin
        r_ar_addr <= w_rd_addr;
        r_ar_cnt  <= r_ar_cnt + 8'd1;
      end
      if (w_rd_load) begin
        r_r_valid <= 1'b1;
        r_r_last  <= w_rd_last;
        if (w_rd_err) begin
          r_r_data <= '0; r_r_resp <= 2'b10;
        end else if (!f_in_range(w_rd_addr)) begin
          r_r_data <= '0; r_r_resp <= 2'b11;
        end else begin
          r_r_data <= w_rd_word; r_r_resp <= 2'b00;
        end
      end else if (w_r_hs) begin
        r_r_valid <= 1'b0;
        r_r_last  <= 1'b0;
      end
    end
  end

  // Sideband fields the responder has no use for.
  logic w_unused;
  assign w_unused = ^{master.clk, master.rstn, master.aw_lock, master.aw_cache, master.aw_prot,
                      master.aw_qos, master.aw_region, master.aw_user, master.w_user,
                      master.ar_lock, master.ar_cache, master.ar_prot, master.ar_qos,
                      master.ar_region, master.ar_user};
endmodule
